muldiv_iter_unit: RTL and testbench

//  Parametrised iterative signed multiply/divide unit for the pipelined core's execute stage.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sign_fix.sv | 61 ++++++
 rtl/muldiv_iter_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The optional early-out for zero operands is enabled by defining MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int EXC_MULT_OVF = 4;
    localparam int EXC_DIV      = 5;

    // Width of a counter that must reach the value `steps`.
    function automatic int step_cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Converts the unsigned magnitude produced by the iterative core back to signed form,
// and decides the exception flag and exception code for the completed op.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               div_zero,
    input  logic [2*WIDTH-1:0] prod_mag,
    input  logic [WIDTH-1:0]   quot_mag,
    output logic [WIDTH-1:0]   result,
    output logic               exception,
    output logic [WIDTH-1:0]   exc_code
);

    logic               neg;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH:0]     prod_upper;
    logic [WIDTH-1:0]   quot_signed;
    logic               mul_ovf;
    logic               div_ovf;

    // Apply the result sign and classify out-of-range results.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a latch behind.
        result    = '0;
        exception = 1'b0;
        exc_code  = '0;

        neg         = sign_a ^ sign_b;
        prod_signed = neg ? -prod_mag : prod_mag;
        quot_signed = neg ? -quot_mag : quot_mag;

        // The product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension.
        prod_upper = prod_signed[2*WIDTH-1:WIDTH-1];
        mul_ovf    = (|prod_upper) && !(&prod_upper);

        // Only MIN / -1 yields a positive quotient with the top magnitude bit set.
        div_ovf = !neg && quot_mag[WIDTH-1];

        if (is_div) begin
            if (div_zero) begin
                result    = '0;
                exception = 1'b1;
                exc_code  = WIDTH'(EXC_DIV);
            end else begin
                result    = quot_signed;
                exception = div_ovf;
                exc_code  = div_ovf ? WIDTH'(EXC_DIV) : '0;
            end
        end else begin
            result    = prod_signed[WIDTH-1:0];
            exception = mul_ovf;
            exc_code  = mul_ovf ? WIDTH'(EXC_MULT_OVF) : '0;
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with busy/kill handshake and a destination tag carried with each op.
// Defining MULDIV_EARLY_OUT_EN lets ops with a zero operand finish after a single step.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             kill,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic [WIDTH-1:0] exc_code,
    output logic [TAG_W-1:0] tag_out
);

    localparam int               CNT_W    = step_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   step_cnt;
    logic [WIDTH-1:0]   work_hi;    // partial product high half / remainder
    logic [WIDTH-1:0]   work_lo;    // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0]   operand_m;  // multiplicand or divisor magnitude
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [TAG_W-1:0]   tag_q;

    logic               start;
    logic               start_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic               early_done;
    logic               last_step;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quot;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exception;
    logic [WIDTH-1:0]   fix_code;

    // Multiply wins when both start strobes arrive together.
    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One radix-2 step: shift-add for multiply, compare-and-subtract for divide.
    always_comb begin
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        step_hi   = work_hi;
        step_lo   = work_lo;
        if (state == ST_DIV) begin
            div_shift = {work_hi, work_lo[WIDTH-1]};
            div_diff  = div_shift - {1'b0, operand_m};
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? operand_m : '0)};
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic op_zero;

    // Remember at accept whether either operand is zero so the first step can finish the op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_zero <= 1'b0;
        end else if (!kill && !busy && start) begin
            op_zero <= (data_operandA == '0) || (data_operandB == '0);
        end
    end

    assign early_done = op_zero;
`else
    assign early_done = 1'b0;
`endif

    // A zero operand short-circuits to a zero magnitude; divide-by-zero is flagged separately.
    assign last_step = busy && ((step_cnt == LAST_CNT) || early_done);
    assign fix_prod  = early_done ? '0 : {step_hi, step_lo};
    assign fix_quot  = early_done ? '0 : step_lo;

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_div    (state == ST_DIV),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .div_zero  (div_zero),
        .prod_mag  (fix_prod),
        .quot_mag  (fix_quot),
        .result    (fix_result),
        .exception (fix_exception),
        .exc_code  (fix_code)
    );

    // Control FSM and datapath registers; kill outranks stepping and starting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            step_cnt       <= '0;
            work_hi        <= '0;
            work_lo        <= '0;
            operand_m      <= '0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            tag_q          <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            exc_code       <= '0;
            tag_out        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            data_resultRDY <= 1'b0;
            if (kill) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (busy) begin
                work_hi  <= step_hi;
                work_lo  <= step_lo;
                step_cnt <= step_cnt + CNT_W'(1);
                if (last_step) begin
                    state          <= ST_DONE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b1;
                    data_result    <= fix_result;
                    data_exception <= fix_exception;
                    exc_code       <= fix_code;
                    tag_out        <= tag_q;
                end
            end else if (start) begin
                state    <= start_div ? ST_DIV : ST_MUL;
                busy     <= 1'b1;
                step_cnt <= '0;
                sign_a   <= data_operandA[WIDTH-1];
                sign_b   <= data_operandB[WIDTH-1];
                div_zero <= start_div && (data_operandB == '0);
                tag_q    <= tag_in;
                work_hi  <= '0;
                if (start_div) begin
                    work_lo   <= mag_a;
                    operand_m <= mag_b;
                end else begin
                    work_lo   <= mag_b;
                    operand_m <= mag_a;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed testbench for muldiv_iter_unit at WIDTH=32, TAG_W=5.
// Zero-operand latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_muldiv_iter_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 32;
`endif

    logic             clock;
    logic             reset;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             kill;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             data_resultRDY;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic [WIDTH-1:0] exc_code;
    logic [TAG_W-1:0] tag_out;

    int checks   = 0;
    int failures = 0;
    int lat;
    int rdy_seen;

    muldiv_iter_unit #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .kill           (kill),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result),
        .data_exception (data_exception),
        .exc_code       (exc_code),
        .tag_out        (tag_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Called at a negedge: drives a start, lets edge E0 sample it, returns at the following negedge.
    task automatic issue(input logic m, input logic d, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        tag_in        = t;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Counts edges after E0 until RDY, bounded; returns in the RDY cycle.
    task automatic wait_rdy(input int start_k, output int k);
        k = start_k;
        while (!data_resultRDY && k < 100) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                          input int exp_lat, input logic [WIDTH-1:0] exp_res, input logic exp_exc,
                          input logic [WIDTH-1:0] exp_code, input logic [TAG_W-1:0] exp_tag);
        int k;
        @(negedge clock);
        issue(m, d, a, b, t);
        check({name, "_busy"}, busy, 1);
        wait_rdy(0, k);
        check({name, "_lat"}, k, exp_lat);
        check({name, "_res"}, data_result, exp_res);
        check({name, "_exc"}, data_exception, exp_exc);
        check({name, "_code"}, exc_code, exp_code);
        check({name, "_tag"}, tag_out, exp_tag);
        check({name, "_busy_done"}, busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        kill          = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tag_in        = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_res", data_result, 0);
        check("rst_exc", data_exception, 0);
        check("rst_code", exc_code, 0);
        check("rst_tag", tag_out, 0);
        reset = 1'b0;

        // Basic multiply and divide vectors.
        run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32, 32'hFFFF_FFEB, 0, 0, 5'd9);
        @(negedge clock);
        check("rdy_pulse", data_resultRDY, 0);
        check("res_held", data_result, 32'hFFFF_FFEB);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32, 32'h0000_0000, 1, 4, 5'd1);
        run_op("mul_min", 1, 0, 32'h8000_0000, 32'd1, 5'd2, 32, 32'h8000_0000, 0, 0, 5'd2);
        run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd3, 32, 32'hFFFF_FFFD, 0, 0, 5'd3);
        run_op("div_5/0", 0, 1, 32'd5, 32'd0, 5'd4, ZERO_LAT, 32'd0, 1, 5, 5'd4);
        run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32, 32'h8000_0000, 1, 5, 5'd5);
        run_op("mul_0x-5", 1, 0, 32'd0, 32'hFFFF_FFFB, 5'd6, ZERO_LAT, 32'd0, 0, 0, 5'd6);

        // Start while busy is dropped; start in the DONE cycle is accepted.
        @(negedge clock);
        issue(1, 0, 32'd3, 32'd4, 5'd1);
        repeat (4) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        tag_in        = 5'd2;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check("ign_busy", busy, 1);
        wait_rdy(5, lat);
        check("ign_lat", lat, 32);
        check("ign_res", data_result, 32'd12);
        check("ign_tag", tag_out, 5'd1);
        issue(1, 0, 32'd6, 32'hFFFF_FFF9, 5'd3);
        check("b2b_rdy_low", data_resultRDY, 0);
        check("b2b_busy", busy, 1);
        wait_rdy(0, lat);
        check("b2b_lat", lat, 32);
        check("b2b_res", data_result, 32'hFFFF_FFD6);
        check("b2b_tag", tag_out, 5'd3);

        // Both strobes high selects multiply.
        run_op("both", 1, 1, 32'd20, 32'd4, 5'd4, 32, 32'd80, 0, 0, 5'd4);

        // Kill mid-op: no RDY, held outputs untouched.
        @(negedge clock);
        issue(1, 0, 32'd5, 32'd5, 5'd8);
        repeat (10) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        check("kill_busy", busy, 0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("kill_no_rdy", rdy_seen, 0);
        check("kill_res_held", data_result, 32'd80);
        check("kill_tag_held", tag_out, 5'd4);

        // Kill in the DONE cycle keeps that RDY but blocks a same-cycle start.
        run_op("kdone", 1, 0, 32'd2, 32'd3, 5'd5, 32, 32'd6, 0, 0, 5'd5);
        kill          = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        #1;
        check("kdone_rdy_kept", data_resultRDY, 1);
        @(negedge clock);
        kill      = 1'b0;
        ctrl_MULT = 1'b0;
        check("kdone_busy", busy, 0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("kdone_no_rdy", rdy_seen, 0);
        check("kdone_res", data_result, 32'd6);

        // Reset mid-op clears every output at once and discards the op.
        @(negedge clock);
        issue(0, 1, 32'd100, 32'd7, 5'd6);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rmid_busy", busy, 0);
        check("rmid_rdy", data_resultRDY, 0);
        check("rmid_res", data_result, 0);
        check("rmid_exc", data_exception, 0);
        check("rmid_code", exc_code, 0);
        check("rmid_tag", tag_out, 0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("rmid_no_rdy", rdy_seen, 0);

        // Unit still works after the mid-op reset.
        run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 5'd7, 32, 32'hFFFF_FFF2, 0, 0, 5'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
